// File: rtl/sp1_ff_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sp1_ff_fifo
//  Purpose  : Single-clock circular-buffer FIFO, read-side companion to the
//             enable-write register sp1_ff. Words written with a wr_en/wr_d
//             strobe are handed to a consumer through a registered read port.
//
//  Parameters
//    DW      data width in bits
//    AW      address width; depth = 2**AW entries
//
//  Ports
//    clk     rising-edge clock
//    rst     asynchronous active-low reset (0 = reset asserted)
//    wr_en   write strobe, samples wr_d on the rising edge
//    wr_d    write data
//    rd_en   read request
//    rd_q    registered read data, holds between reads
//    rd_vld  one-cycle pulse, rd_q was updated at the previous edge
//    full    count == 2**AW
//    empty   count == 0
//    count   number of stored entries (AW+1 bits)
//    ovf     sticky: a write was dropped because the FIFO was full
//    udf     sticky: a read was refused because the FIFO was empty
//
//  Revision : 1.0  initial release
// ============================================================================
module sp1_ff_fifo #(
  parameter int DW = 32,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_d,
  input  logic          rd_en,
  output logic [DW-1:0] rd_q,
  output logic          rd_vld,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          udf
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);

  // Storage is deliberately not reset; only the pointers define validity.
  logic [DW-1:0] mem [DEPTH];

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wp;
  logic [AW:0] rp;

  logic wr_ok;
  logic rd_ok;

  assign count = wp - rp;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A write into a full FIFO is still accepted when a read frees the oldest
  // slot in the same cycle. A read of an empty FIFO is never bypassed from a
  // concurrent write.
  assign wr_ok = wr_en && (!full || rd_en);
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wp[AW-1:0]] <= wr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp     <= '0;
      rp     <= '0;
      rd_q   <= '0;
      rd_vld <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      rd_vld <= rd_ok;
      if (wr_ok) begin
        wp <= wp + PTR_ONE;
      end
      if (rd_ok) begin
        rd_q <= mem[rp[AW-1:0]];
        rp   <= rp + PTR_ONE;
      end
      if (wr_en && full && !rd_en) begin
        ovf <= 1'b1;
      end
      if (rd_en && empty) begin
        udf <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/sp1_ff_fifo.md
# sp1_ff_fifo

Read-side companion to the enable-write register `sp1_ff`. It buffers words written with an `en`/`d` strobe and hands them to a consumer through a registered read port with full/empty status. It sits between a single-cycle writer (same `en`/`d` strobe convention as `sp1_ff`) and a reader that pulls data at its own rate, all in one clock domain.

## Interface
- `DW`, 32, data width in bits
- `AW`, 2, address width; depth = 2^AW entries (default 4)

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-low (0 = reset asserted)
- `wr_en`  in  1  write strobe; samples `wr_d` on the rising edge
- `wr_d`  in  DW  write data
- `rd_en`  in  1  read request
- `rd_q`  out  DW  read data, registered; holds its value between reads
- `rd_vld`  out  1  one-cycle pulse; `rd_q` updated this cycle
- `full`  out  1  `count == 2^AW`
- `empty`  out  1  `count == 0`
- `count`  out  AW+1  number of stored entries
- `ovf`  out  1  sticky overflow: a write was dropped
- `udf`  out  1  sticky underflow: a read was refused

## Operation
- Storage: 2^AW × DW array. Write and read pointers are AW+1 bits wide. The MSB is the wrap bit, and the low AW bits index the array. Pointers wrap modulo 2^(AW+1).
- `count = wp - rp` (AW+1 bit, modulo). `full` and `empty` decode from `count`, combinationally from registered state.
- Write accepted when `wr_en && (!full || rd_en)`. The array entry at `wp` takes `wr_d`, and `wp` increments.
- Read accepted when `rd_en && !empty`. `rd_q` takes the entry at `rp`, `rp` increments, and `rd_vld` = 1 the next cycle.
- Write while full without a simultaneous read: data dropped, state unchanged, `ovf` set.
- Read while empty: refused, `rd_q` unchanged, `rd_vld` = 0, `udf` set. This applies even when a write arrives in the same cycle; the written word is not bypassed.
- Simultaneous read + write when neither edge case applies: both accepted, `count` unchanged.
- Simultaneous read + write when full: both accepted. The read takes the oldest entry, the write fills the freed slot, and `ovf` is not set.
- `ovf` and `udf` clear only on reset.
- `wr_d` is ignored when `wr_en` = 0, including X or Z values. Array contents must not change.
- `wr_en` or `rd_en` = X: pointer and flag updates may go X in simulation. The bench checks that the block recovers cleanly after reset.
- No internal state machine beyond the pointers. The block is a single-clock circular buffer.

## Timing
- Reset asserted (`rst` = 0), asynchronous with immediate effect:
  - `wp` = `rp` = 0, `count` = 0
  - `empty` = 1, `full` = 0
  - `rd_q` = 0, `rd_vld` = 0
  - `ovf` = `udf` = 0
  - Array contents are not reset.
- Reset deassertion is sampled synchronously; the first write is accepted on the first rising edge with `rst` = 1.
- Reset asserted mid-operation discards all stored entries and any pending `rd_vld`.
- Write to status: `count`, `empty` and `full` reflect an accepted write 1 cycle after the edge that sampled it.
- Write to read: a word written at edge N can be read at edge N+1 at the earliest (`rd_en` high at N+1). It appears on `rd_q` with `rd_vld` after edge N+1, so minimum write-to-data latency is 2 cycles.
- Read latency: 1 cycle from the sampling edge to `rd_q`/`rd_vld`.
- Back-to-back reads with `rd_en` held high: one word per cycle until empty. `rd_vld` is high on every cycle that follows an accepted read.
- Stimulus convention: drive inputs 1 time unit after the falling edge and sample outputs 1 time unit after the rising edge.

## Test plan
- Reset then idle:
  - Hold `rst` = 0 for 5 cycles, then release.
  - Required: `empty` = 1, `full` = 0, `count` = 0, `rd_q` = 0, `ovf` = `udf` = 0.
  - `rd_en` pulse: `udf` = 1, `rd_vld` stays 0.
- Ordered fill/drain:
  - Write ffffffff, 00000000, 12345678, cafecafe.
  - After the writes: `full` = 1, `count` = 4.
  - Four reads return the same order, each with a `rd_vld` pulse; then `empty` = 1.
- Overflow and full-simultaneous:
  - Fill with 33333333, cccccccc, 55555555, aaaaaaaa, then write beefbeef alone: dropped, `ovf` = 1, `count` = 4.
  - Then read + write 12345678 in the same cycle: `rd_q` = 33333333, `count` stays 4.
  - Draining returns cccccccc, 55555555, aaaaaaaa, 12345678.
- Pointer wrap:
  - Stream 10 words 00000001..0000000a with write + read overlapping every cycle after the first.
  - Required: `rd_q` sequence matches, `count` never exceeds 1, no flags set.
- Garbage data while idle:
  - Store 00000000, then drive `wr_en` = 0, `wr_d` = all-X for 1 cycle.
  - Read returns 00000000, `count` unaffected.
- Reset mid-stream:
  - Write 3 words, assert `rst` between edges.
  - Required: outputs return to their reset values immediately, no `rd_vld`.
  - Next write beefbeef + read returns beefbeef.
